clock_tap_selector: RTL and testbench

- Upstream stage of the 4:1 clock mux in the NES receiver clock path.
- Generates the four divided square-wave taps (zero, one, two, three) from a free-running prescaler.
- Owns the 2-bit clockSelect that drives the mux.
- Applies select changes only when both the outgoing and the incoming taps are low. This gives a glitch-free handoff at the mux output.

---
 rtl/clock_tap_selector.sv | 97 +++++++++
 tb/tb_clock_tap_selector.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_tap_selector.sv
// Divided clock taps from a free-running prescaler, plus a glitch-free select for the 4:1 tap mux.
// A select change takes effect only on an edge where both the outgoing and the incoming taps are low.
module clock_tap_selector #(
  parameter int         CW          = 24,
  parameter int         TAP0        = 20,
  parameter int         TAP1        = 21,
  parameter int         TAP2        = 22,
  parameter int         TAP3        = 23,
  parameter logic [1:0] DEFAULT_SEL = 2'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] selectRequest,
  input  logic       selectLoad,
  output logic       zero,
  output logic       one,
  output logic       two,
  output logic       three,
  output logic [1:0] clockSelect,
  output logic       busy,
  output logic       switchDone
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_LOW = 2'd1,
    SETTLE   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      req_q, req_d;
  logic [3:0]      taps;
  logic            cur_tap;
  logic            req_tap;

  // Taps are plain flop bits of the prescaler, so they carry no input-to-output path.
  always_comb begin
    taps    = {cnt_q[TAP3], cnt_q[TAP2], cnt_q[TAP1], cnt_q[TAP0]};
    cur_tap = taps[sel_q];
    req_tap = taps[req_q];
  end

  always_comb begin
    cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    state_d = state_q;
    sel_d   = sel_q;
    req_d   = req_q;
    case (state_q)
      IDLE: begin
        if (selectLoad && (selectRequest != sel_q)) begin
          req_d   = selectRequest;
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        // Both taps low means the mux output is low before and after the swap.
        if (!cur_tap && !req_tap) begin
          sel_d   = req_q;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      state_q <= IDLE;
      sel_q   <= DEFAULT_SEL;
      req_q   <= 2'd0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      sel_q   <= sel_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    zero        = taps[0];
    one         = taps[1];
    two         = taps[2];
    three       = taps[3];
    clockSelect = sel_q;
    busy        = (state_q != IDLE);
    switchDone  = (state_q == SETTLE);
  end

endmodule

// File: tb/tb_clock_tap_selector.sv
// Purpose: directed and random checks of the tap selector (5-bit prescaler, taps on bits 1..4).
// Latency: checks sample outputs at the falling edge after each rising edge.
// Backpressure: none; selectLoad is a strobe and requests made while busy are ignored.
module tb_clock_tap_selector;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] selectRequest;
    logic       selectLoad;
    logic       zero, one, two, three;
    logic [1:0] clockSelect;
    logic       busy, switchDone;

    int         errors = 0;
    int         checks = 0;
    logic [4:0] exp_cnt;

    always #5 clk = ~clk;

    clock_tap_selector #(
        .CW(5), .TAP0(1), .TAP1(2), .TAP2(3), .TAP3(4), .DEFAULT_SEL(2'd0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .selectRequest(selectRequest),
        .selectLoad(selectLoad),
        .zero(zero),
        .one(one),
        .two(two),
        .three(three),
        .clockSelect(clockSelect),
        .busy(busy),
        .switchDone(switchDone)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        exp_cnt = reset ? 5'd0 : exp_cnt + 5'd1;
        @(negedge clk);
    endtask

    task automatic step_to(input logic [4:0] target);
        for (int i = 0; i < 40 && exp_cnt != target; i++) step();
    endtask

    task automatic test_reset();
        reset = 1'b1; selectLoad = 1'b0; selectRequest = 2'd0;
        step(); step();
        reset = 1'b0;
        checks++;
        if ({three, two, one, zero, clockSelect, busy, switchDone} !== 8'b0) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b",
                     {three, two, one, zero, clockSelect, busy, switchDone}, 8'b0);
        end
        repeat (6) step();
        checks++;
        if ({three, two, one, zero} !== 4'b0011) begin
            errors++;
            $display("FAIL taps_cnt6: got %b expected %b", {three, two, one, zero}, 4'b0011);
        end
        step_to(5'd31);
        checks++;
        if ({three, two, one, zero} !== 4'b1111) begin
            errors++;
            $display("FAIL taps_cnt31: got %b expected %b", {three, two, one, zero}, 4'b1111);
        end
        step();
        checks++;
        if ({three, two, one, zero} !== 4'b0000) begin
            errors++;
            $display("FAIL taps_wrap: got %b expected %b", {three, two, one, zero}, 4'b0000);
        end
    endtask

    task automatic test_switch();
        step_to(5'd2);
        selectRequest = 2'd3; selectLoad = 1'b1;
        step();
        selectLoad = 1'b0;
        checks++;
        if ({clockSelect, busy, switchDone} !== 4'b0010) begin
            errors++;
            $display("FAIL switch_cnt3: got %b expected %b", {clockSelect, busy, switchDone}, 4'b0010);
        end
        step();
        checks++;
        if ({clockSelect, busy, switchDone} !== 4'b0010) begin
            errors++;
            $display("FAIL switch_cnt4: got %b expected %b", {clockSelect, busy, switchDone}, 4'b0010);
        end
        step();
        checks++;
        if ({clockSelect, busy, switchDone} !== 4'b1111) begin
            errors++;
            $display("FAIL switch_cnt5: got %b expected %b", {clockSelect, busy, switchDone}, 4'b1111);
        end
        step();
        checks++;
        if ({clockSelect, busy, switchDone} !== 4'b1100) begin
            errors++;
            $display("FAIL switch_cnt6: got %b expected %b", {clockSelect, busy, switchDone}, 4'b1100);
        end
    endtask

    task automatic test_same_select();
        selectRequest = 2'd3; selectLoad = 1'b1;
        step();
        selectLoad = 1'b0;
        checks++;
        if ({clockSelect, busy, switchDone} !== 4'b1100) begin
            errors++;
            $display("FAIL same_sel_a: got %b expected %b", {clockSelect, busy, switchDone}, 4'b1100);
        end
        step();
        checks++;
        if ({clockSelect, busy, switchDone} !== 4'b1100) begin
            errors++;
            $display("FAIL same_sel_b: got %b expected %b", {clockSelect, busy, switchDone}, 4'b1100);
        end
    endtask

    task automatic test_ignore_during_wait();
        step_to(5'd8);
        selectRequest = 2'd2; selectLoad = 1'b1;
        step();
        selectLoad = 1'b0;
        checks++;
        if ({clockSelect, busy, switchDone} !== 4'b1110) begin
            errors++;
            $display("FAIL wait_enter: got %b expected %b", {clockSelect, busy, switchDone}, 4'b1110);
        end
        step();
        selectRequest = 2'd1; selectLoad = 1'b1;
        step();
        selectLoad = 1'b0;
        checks++;
        if ({clockSelect, busy, switchDone} !== 4'b1110) begin
            errors++;
            $display("FAIL wait_ignore: got %b expected %b", {clockSelect, busy, switchDone}, 4'b1110);
        end
        step_to(5'd0);
        checks++;
        if ({clockSelect, busy, switchDone} !== 4'b1110) begin
            errors++;
            $display("FAIL wait_cnt0: got %b expected %b", {clockSelect, busy, switchDone}, 4'b1110);
        end
        step();
        checks++;
        if ({clockSelect, busy, switchDone} !== 4'b1011) begin
            errors++;
            $display("FAIL wait_done: got %b expected %b", {clockSelect, busy, switchDone}, 4'b1011);
        end
        step();
        checks++;
        if ({clockSelect, busy, switchDone} !== 4'b1000) begin
            errors++;
            $display("FAIL wait_idle: got %b expected %b", {clockSelect, busy, switchDone}, 4'b1000);
        end
        selectRequest = 2'd1; selectLoad = 1'b1;
        step();
        selectLoad = 1'b0;
        checks++;
        if ({clockSelect, busy, switchDone} !== 4'b1010) begin
            errors++;
            $display("FAIL reload_wait: got %b expected %b", {clockSelect, busy, switchDone}, 4'b1010);
        end
        step();
        checks++;
        if ({clockSelect, busy, switchDone} !== 4'b0111) begin
            errors++;
            $display("FAIL reload_done: got %b expected %b", {clockSelect, busy, switchDone}, 4'b0111);
        end
        step();
        checks++;
        if ({clockSelect, busy, switchDone} !== 4'b0100) begin
            errors++;
            $display("FAIL reload_idle: got %b expected %b", {clockSelect, busy, switchDone}, 4'b0100);
        end
    endtask

    task automatic test_reset_mid_wait();
        selectRequest = 2'd3; selectLoad = 1'b1;
        step();
        selectLoad = 1'b0;
        checks++;
        if ({clockSelect, busy, switchDone} !== 4'b0110) begin
            errors++;
            $display("FAIL rst_wait_enter: got %b expected %b", {clockSelect, busy, switchDone}, 4'b0110);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({three, two, one, zero, clockSelect, busy, switchDone} !== 8'b0) begin
            errors++;
            $display("FAIL rst_mid_wait: got %b expected %b",
                     {three, two, one, zero, clockSelect, busy, switchDone}, 8'b0);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if ({clockSelect, busy, switchDone} !== 4'b0000) begin
                errors++;
                $display("FAIL rst_req_lost cyc%0d: got %b expected %b", i,
                         {clockSelect, busy, switchDone}, 4'b0000);
            end
        end
        reset = 1'b1; selectRequest = 2'd2; selectLoad = 1'b1;
        step();
        reset = 1'b0; selectLoad = 1'b0;
        checks++;
        if ({three, two, one, zero, clockSelect, busy, switchDone} !== 8'b0) begin
            errors++;
            $display("FAIL rst_vs_load: got %b expected %b",
                     {three, two, one, zero, clockSelect, busy, switchDone}, 8'b0);
        end
        step();
        checks++;
        if ({clockSelect, busy, switchDone} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_vs_load_after: got %b expected %b", {clockSelect, busy, switchDone}, 4'b0000);
        end
    endtask

    task automatic test_random_traffic();
        logic [3:0] prev_taps;
        logic [1:0] prev_cs;
        logic [1:0] exp_req;
        logic       changed;
        exp_req = clockSelect;
        for (int i = 0; i < 2000; i++) begin
            selectLoad    = ($urandom_range(0, 5) == 0);
            selectRequest = 2'($urandom_range(0, 3));
            if (selectLoad && !busy && (selectRequest != clockSelect)) exp_req = selectRequest;
            prev_taps = {three, two, one, zero};
            prev_cs   = clockSelect;
            step();
            checks++;
            if ({three, two, one, zero} !== {exp_cnt[4], exp_cnt[3], exp_cnt[2], exp_cnt[1]}) begin
                errors++;
                $display("FAIL rnd_taps cyc%0d: got %b expected %b", i, {three, two, one, zero},
                         {exp_cnt[4], exp_cnt[3], exp_cnt[2], exp_cnt[1]});
            end
            changed = (clockSelect != prev_cs);
            if (changed) begin
                checks++;
                if (prev_taps[prev_cs] || prev_taps[clockSelect] || (clockSelect !== exp_req)) begin
                    errors++;
                    $display("FAIL rnd_handoff cyc%0d: sel %0d->%0d taps %b, required req %0d with both taps low",
                             i, prev_cs, clockSelect, prev_taps, exp_req);
                end
            end
            checks++;
            if (switchDone !== changed) begin
                errors++;
                $display("FAIL rnd_switchdone cyc%0d: got %b expected %b", i, switchDone, changed);
            end
        end
        selectLoad = 1'b0;
    endtask

    initial begin
        reset = 1'b1; selectLoad = 1'b0; selectRequest = 2'd0;
        test_reset();
        test_switch();
        test_same_select();
        test_ignore_during_wait();
        test_reset_mid_wait();
        test_random_traffic();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        if (errors == 0)
            $display("PASS");
        else
            $display("FAIL");
        $finish;
    end

endmodule
